// File: rtl/i2c_slave_regfile.sv
// I2C slave register bank in the system clock domain. SCL/SDA are synchronised,
// glitch-filtered and edge-detected; a pointer byte selects the first register,
// and the pointer auto-increments on both writes and reads.
module i2c_slave_regfile #(
  parameter logic [6:0]  I2C_ADR    = 7'h27,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned FILTER_LEN = 3,
  parameter logic [7:0]  RESET_VAL  = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic                        busy
);

  localparam int unsigned PW = $clog2(NUM_REGS);
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_e;

  // Line bundles: bit 0 = SCL, bit 1 = SDA
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         filt_q, filt_d, prev_q, prev_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  state_e                   state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]               shreg_q, shreg_d;
  logic [7:0]               rd_sh_q, rd_sh_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     rw_q, rw_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     wr_stb_q, wr_stb_d;
  logic [PW-1:0]            wr_idx_q, wr_idx_d;
  logic                     busy_q, busy_d;

  logic       scl_f, sda_f, start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0] rx_byte;

  // Synchroniser and per-line filter: a line flips only after FILTER_LEN equal samples
  always_comb begin
    sync1_d = {sda_i, scl_i};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    prev_d  = filt_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign start_ev = prev_q[1] & ~sda_f & prev_q[0] & scl_f;
  assign stop_ev  = ~prev_q[1] & sda_f & prev_q[0] & scl_f;
  assign scl_rise = ~prev_q[0] & scl_f;
  assign scl_fall = prev_q[0] & ~scl_f;
  assign rx_byte  = {shreg_q[6:0], sda_f};

  // Protocol FSM: bus conditions, byte shifting, register access and SDA drive
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rd_sh_d   = rd_sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    regs_d    = regs_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    busy_d    = busy_q;

    if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_ev) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && bit_cnt_q != BW'(8)) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (state_q == S_WDATA && bit_cnt_q == BW'(7)) begin
              regs_d[ptr_q] = rx_byte;
              wr_stb_d      = 1'b1;
              wr_idx_d      = ptr_q;
              ptr_d         = ptr_q + PW'(1);
            end
          end else if (scl_fall && bit_cnt_q == BW'(8)) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
            if (state_q == S_ADDR) begin
              if (shreg_q[7:1] == I2C_ADR) begin
                state_d = S_ADDR_ACK;
                rw_d    = shreg_q[0];
              end else begin
                state_d  = S_IDLE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              state_d = S_PTR_ACK;
              ptr_d   = shreg_q[PW-1:0];
            end else begin
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d  = S_RDATA;
              rd_sh_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = S_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = S_WDATA;
            sda_oe_d = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise && bit_cnt_q != BW'(8)) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == BW'(8)) begin
              state_d   = S_RDATA_ACK;
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end else begin
              rd_sh_d  = {rd_sh_q[6:0], 1'b0};
              sda_oe_d = ~rd_sh_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          // bit_cnt marks that the master's ACK has been sampled
          if (scl_rise) begin
            if (sda_f) begin
              state_d = S_IDLE;
            end else begin
              ptr_d     = ptr_q + PW'(1);
              bit_cnt_d = BW'(1);
            end
          end else if (scl_fall && bit_cnt_q == BW'(1)) begin
            state_d   = S_RDATA;
            bit_cnt_d = '0;
            rd_sh_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  // Input path registers; filters idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rd_sh_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      regs_q    <= {NUM_REGS{RESET_VAL}};
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rd_sh_q   <= rd_sh_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      regs_q    <= regs_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign regs_o = regs_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, open-drain SDA, and a
// register/pointer reference model kept as a plain array plus an index.
module tb_i2c_slave_regfile;

  localparam int         NR  = 8;
  localparam int         FL  = 3;
  localparam int         PW  = $clog2(NR);
  localparam logic [6:0] ADR = 7'h27;
  localparam logic [7:0] RV  = 8'h5A;
  localparam int         Q   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          scl_i, sda_i;
  logic          sda_oe, wr_stb, busy;
  logic [NR*8-1:0] regs_o;
  logic [PW-1:0] wr_idx;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  i2c_slave_regfile #(.I2C_ADR(ADR), .NUM_REGS(NR), .FILTER_LEN(FL), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .regs_o(regs_o), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Observers: cycles with SDA pulled low, and every write strobe index
  int            oe_cnt = 0;
  logic [PW-1:0] stb_log [$];
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (wr_stb) stb_log.push_back(wr_idx);
  end

  // Reference model
  logic [7:0] mregs [NR];
  int         mptr;

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) mregs[k] = RV;
    mptr = 0;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    mregs[mptr] = d;
    mptr = (mptr + 1) % NR;
  endfunction

  function automatic logic [NR*8-1:0] exp_image();
    logic [NR*8-1:0] v;
    for (int k = 0; k < NR; k++) v[8*k +: 8] = mregs[k];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; g=1 adds a short SCL pulse in the low phase, g=2 a short SDA flip in the high phase
  task automatic xfer_bit(input logic b, input int g, output logic r);
    m_sda = b;
    if (g == 1) begin
      tick(2); m_scl = 1'b1; tick(FL - 1); m_scl = 1'b0; tick(Q - 1 - FL);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1;
    tick(Q);
    r = sda_i;
    if (g == 2) begin
      m_sda = ~b; tick(FL - 1); m_sda = b; tick(Q - FL + 1);
    end else begin
      tick(Q);
    end
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic write_byte_g(input logic [7:0] b, input int gi, input int g, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) xfer_bit(b[7-i], (i == gi) ? g : 0, r);
    xfer_bit(1'b1, 0, r);
    ack = ~r;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_byte_g(b, 8, 0, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic r;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 0, r);
      d[7-i] = r;
    end
    xfer_bit(nack, 0, r);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    model_reset();
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
    n_chk++; if (wr_idx !== '0) begin n_fail++; $display("FAIL reset_wr_idx: got %0d want 0", wr_idx); end
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL reset_regs: got %h want %h", regs_o, exp_image()); end
  endtask

  task automatic test_write_burst();
    logic ack;
    logic [7:0] seq [4];
    int s0;
    seq = '{8'h4E, 8'h02, 8'hA5, 8'h3C};
    s0 = stb_log.size();
    // START with busy latency probe: filtered edge after 2+FL clk, busy one clk later
    m_sda = 1'b0;
    tick(2 + FL);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_early: got %b want 0", busy); end
    tick(1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy); end
    tick(Q - 3 - FL); m_scl = 1'b0; tick(Q);
    for (int i = 0; i < 4; i++) begin
      write_byte(seq[i], ack);
      n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL burst_ack%0d: got nack want ack", i); end
    end
    mptr = 2; model_write(8'hA5); model_write(8'h3C);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b want 1", busy); end
    i2c_stop();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_stop: got %b want 0", busy); end
    n_chk++; if (regs_o[23:16] !== 8'hA5) begin n_fail++; $display("FAIL burst_reg2: got %h want a5", regs_o[23:16]); end
    n_chk++; if (regs_o[31:24] !== 8'h3C) begin n_fail++; $display("FAIL burst_reg3: got %h want 3c", regs_o[31:24]); end
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL burst_regs: got %h want %h", regs_o, exp_image()); end
    n_chk++;
    if (stb_log.size() - s0 !== 2) begin
      n_fail++; $display("FAIL burst_stb_count: got %0d want 2", stb_log.size() - s0);
    end else begin
      n_chk++; if (stb_log[s0] !== PW'(2)) begin n_fail++; $display("FAIL burst_idx0: got %0d want 2", stb_log[s0]); end
      n_chk++; if (stb_log[s0+1] !== PW'(3)) begin n_fail++; $display("FAIL burst_idx1: got %0d want 3", stb_log[s0+1]); end
    end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] seq [4];
    int s0;
    seq = '{8'h4E, 8'h07, 8'h11, 8'h22};
    s0 = stb_log.size();
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(seq[i], ack);
      n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrap_ack%0d: got nack want ack", i); end
    end
    i2c_stop();
    mptr = 7; model_write(8'h11); model_write(8'h22);
    n_chk++; if (regs_o[63:56] !== 8'h11 || regs_o[7:0] !== 8'h22) begin
      n_fail++; $display("FAIL wrap_regs70: got %h/%h want 11/22", regs_o[63:56], regs_o[7:0]);
    end
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL wrap_regs: got %h want %h", regs_o, exp_image()); end
    n_chk++;
    if (stb_log.size() - s0 !== 2) begin
      n_fail++; $display("FAIL wrap_stb_count: got %0d want 2", stb_log.size() - s0);
    end else begin
      n_chk++; if (stb_log[s0] !== PW'(7) || stb_log[s0+1] !== PW'(0)) begin
        n_fail++; $display("FAIL wrap_idx: got %0d,%0d want 7,0", stb_log[s0], stb_log[s0+1]);
      end
    end
  endtask

  task automatic test_read_rs();
    logic ack;
    logic [7:0] d;
    int s0;
    s0 = stb_log.size();
    i2c_start();
    write_byte(8'h4E, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got nack want ack"); end
    write_byte(8'h02, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_ptr_ack: got nack want ack"); end
    mptr = 2;
    i2c_start();
    write_byte(8'h4F, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_r_ack: got nack want ack"); end
    read_byte(d, 1'b0);
    n_chk++; if (d !== mregs[mptr] || d !== 8'hA5) begin n_fail++; $display("FAIL rd_byte0: got %h want a5", d); end
    mptr = (mptr + 1) % NR;
    read_byte(d, 1'b1);
    n_chk++; if (d !== mregs[mptr] || d !== 8'h3C) begin n_fail++; $display("FAIL rd_byte1: got %h want 3c", d); end
    tick(Q);
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_nack_release: got %b want 0", sda_oe); end
    i2c_stop();
    n_chk++; if (stb_log.size() !== s0) begin n_fail++; $display("FAIL rd_no_stb: got %0d strobes want 0", stb_log.size() - s0); end
    // Pointer persists: a bare read resumes where the NACKed read left off
    i2c_start();
    write_byte(8'h4F, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_persist_ack: got nack want ack"); end
    read_byte(d, 1'b1);
    n_chk++; if (d !== mregs[mptr]) begin n_fail++; $display("FAIL rd_persist: got %h want %h", d, mregs[mptr]); end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic ack;
    int o0, s0;
    o0 = oe_cnt; s0 = stb_log.size();
    i2c_start();
    write_byte(8'h50, ack);
    n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mm_addr_ack: got ack want nack"); end
    write_byte(8'hFF, ack);
    write_byte(8'hFF, ack);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mm_busy: got %b want 1", busy); end
    i2c_stop();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy_stop: got %b want 0", busy); end
    n_chk++; if (oe_cnt !== o0) begin n_fail++; $display("FAIL mm_sda_oe: got %0d driven cycles want 0", oe_cnt - o0); end
    n_chk++; if (stb_log.size() !== s0) begin n_fail++; $display("FAIL mm_stb: got %0d strobes want 0", stb_log.size() - s0); end
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL mm_regs: got %h want %h", regs_o, exp_image()); end
  endtask

  task automatic test_glitch();
    logic ack;
    int s0;
    s0 = stb_log.size();
    i2c_start();
    write_byte(8'h4E, ack);
    write_byte(8'h04, ack);
    mptr = 4;
    write_byte_g(8'h96, 3, 1, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gl_scl_ack: got nack want ack"); end
    model_write(8'h96);
    write_byte_g(8'h69, 5, 2, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gl_stop_ack: got nack want ack"); end
    model_write(8'h69);
    write_byte_g(8'hC3, 0, 2, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gl_start_ack: got nack want ack"); end
    model_write(8'hC3);
    i2c_stop();
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL gl_regs: got %h want %h", regs_o, exp_image()); end
    n_chk++; if (stb_log.size() - s0 !== 3) begin n_fail++; $display("FAIL gl_stb: got %0d strobes want 3", stb_log.size() - s0); end
  endtask

  task automatic test_abort();
    logic ack, r;
    logic [7:0] d;
    int s0;
    s0 = stb_log.size();
    i2c_start();
    write_byte(8'h4E, ack);
    write_byte(8'h01, ack);
    mptr = 1;
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, 0, r);
    i2c_stop();
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL ab_regs: got %h want %h", regs_o, exp_image()); end
    n_chk++; if (stb_log.size() !== s0) begin n_fail++; $display("FAIL ab_stb: got %0d strobes want 0", stb_log.size() - s0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", busy); end
    i2c_start();
    write_byte(8'h4F, ack);
    read_byte(d, 1'b1);
    n_chk++; if (d !== mregs[mptr]) begin n_fail++; $display("FAIL ab_ptr_kept: got %h want %h", d, mregs[mptr]); end
    i2c_stop();
  endtask

  task automatic test_reset_mid_read();
    logic ack, r;
    logic [7:0] d;
    int o0, s0;
    i2c_start();
    write_byte(8'h4E, ack);
    write_byte(8'h02, ack);
    i2c_start();
    write_byte(8'h4F, ack);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, 0, r);
    // Bit 3 (slave drives 0 for A5) interrupted by reset in the SCL-low phase
    m_sda = 1'b1;
    tick(Q / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmr_sda_oe: got %b want 0", sda_oe); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy: got %b want 0", busy); end
    n_chk++; if (regs_o !== {NR{RV}}) begin n_fail++; $display("FAIL rmr_regs: got %h want %h", regs_o, {NR{RV}}); end
    o0 = oe_cnt; s0 = stb_log.size();
    tick(Q - Q / 2 - 1); m_scl = 1'b1; tick(2 * Q); m_scl = 1'b0; tick(Q);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, 0, r);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy_after: got %b want 0", busy); end
    i2c_stop();
    n_chk++; if (oe_cnt !== o0) begin n_fail++; $display("FAIL rmr_ignored: got %0d driven cycles want 0", oe_cnt - o0); end
    n_chk++; if (stb_log.size() !== s0) begin n_fail++; $display("FAIL rmr_stb: got %0d strobes want 0", stb_log.size() - s0); end
    // Fresh transaction after reset
    i2c_start();
    write_byte(8'h4E, ack);
    write_byte(8'h06, ack);
    mptr = 6;
    write_byte(8'hE7, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rmr_fresh_ack: got nack want ack"); end
    model_write(8'hE7);
    i2c_stop();
    n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL rmr_fresh_regs: got %h want %h", regs_o, exp_image()); end
    i2c_start();
    write_byte(8'h4F, ack);
    read_byte(d, 1'b1);
    n_chk++; if (d !== mregs[mptr]) begin n_fail++; $display("FAIL rmr_fresh_read: got %h want %h", d, mregs[mptr]); end
    i2c_stop();
  endtask

  task automatic test_random();
    logic ack;
    logic [7:0] d, p;
    int n;
    for (int it = 0; it < 4; it++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      i2c_start();
      write_byte(8'h4E, ack);
      n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd_w_addr_ack it%0d: got nack want ack", it); end
      write_byte(p, ack);
      mptr = int'(p) % NR;
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        write_byte(d, ack);
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd_w_data_ack it%0d b%0d: got nack want ack", it, j); end
        model_write(d);
      end
      i2c_stop();
      n_chk++; if (regs_o !== exp_image()) begin n_fail++; $display("FAIL rnd_regs it%0d: got %h want %h", it, regs_o, exp_image()); end
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      i2c_start();
      write_byte(8'h4E, ack);
      write_byte(p, ack);
      mptr = int'(p) % NR;
      i2c_start();
      write_byte(8'h4F, ack);
      n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd_r_addr_ack it%0d: got nack want ack", it); end
      for (int j = 0; j < n; j++) begin
        read_byte(d, j == n - 1);
        n_chk++; if (d !== mregs[mptr]) begin n_fail++; $display("FAIL rnd_read it%0d b%0d: got %h want %h", it, j, d, mregs[mptr]); end
        if (j != n - 1) mptr = (mptr + 1) % NR;
      end
      i2c_stop();
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_wrap();
    test_read_rs();
    test_mismatch();
    test_glitch();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
